// File: rtl/uart_tx_queue.sv
// Byte FIFO between uart_rx and uart_tx, launching bytes one at a time via start/busy.
// Define UART_TXQ_OVERWRITE_EN to make writes to a full queue replace the oldest byte.
module uart_tx_queue #(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_wr_data,
  input  logic                   i_wr_en,
  input  logic                   i_tx_busy,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_WAIT + 1);

`ifdef UART_TXQ_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;

  logic full_now;
  logic pop;
  logic push;
  logic overflow_hit;
  logic mem_we;

  assign full_now     = (count_q == CW'(DEPTH));
  assign pop          = (state_q == IDLE) && (count_q != '0);
  // A full queue still accepts a write when the launcher frees a slot this cycle.
  assign push         = i_wr_en && (!full_now || pop);
  assign overflow_hit = i_wr_en && full_now && !pop;

  always_comb begin
    mem_we   = push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (OVERWRITE && overflow_hit) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_q | overflow_hit;
    end
  end

  // Launcher; o_tx_data is loaded only when entering LAUNCH so it stays stable per frame.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q + TW'(1) == TW'(BUSY_WAIT)) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = overflow_q;

endmodule
